// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu micro-op sequencer: fetches a macro-opcode, maps it to a ucode flow entry
// and steps the micro-PC through the ROM until the flow signals its end.
module dzcpu_uop_sequencer #(
  parameter int unsigned UADDR_W = 8,
  parameter int unsigned FLOW_W  = 4
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic [7:0]         iMemData,
  input  logic               iStall,
  input  logic [UADDR_W-1:0] iFlowIdx,
  input  logic [UADDR_W-1:0] iCbFlowIdx,
  input  logic [FLOW_W-1:0]  iUopFlow,
  input  logic               iFlagZ,
  output logic [UADDR_W-1:0] oUopAddr,
  output logic               oUopExec,
  output logic               oIncPc,
  output logic               oFlagUpd,
  output logic [7:0]         oOpcode,
  output logic               oFetch,
  output logic               oInstrDone,
  output logic               oSeqError
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    F_OP         = 4'd0,
    F_INC        = 4'd1,
    F_EOF        = 4'd2,
    F_INC_EOF    = 4'd3,
    F_EOF_FU     = 4'd4,
    F_INC_EOF_FU = 4'd5,
    F_INC_EOF_Z  = 4'd6,
    F_INC_EOF_NZ = 4'd7,
    F_NOP        = 4'd8,
    F_JCB        = 4'd9
  } flow_e;

  state_e             state;
  logic [UADDR_W-1:0] upc;
  logic [7:0]         opcode;
  logic               seq_error;

  flow_e flow;
  logic  exec;
  logic  inc_c;
  logic  fu_c;
  logic  done_c;
  logic  adv_c;
  logic  jump_c;

  // Unassigned flow codes decode as plain OP.
  assign flow = (iUopFlow <= FLOW_W'(9)) ? flow_e'(iUopFlow[3:0]) : F_OP;
  assign exec = (state == S_EXEC) && !iStall;

  always_comb begin
    inc_c  = 1'b0;
    fu_c   = 1'b0;
    done_c = 1'b0;
    adv_c  = 1'b0;
    jump_c = 1'b0;
    case (flow)
      F_INC:        begin inc_c = 1'b1; adv_c = 1'b1; end
      F_EOF:        done_c = 1'b1;
      F_INC_EOF:    begin inc_c = 1'b1; done_c = 1'b1; end
      F_EOF_FU:     begin fu_c = 1'b1; done_c = 1'b1; end
      F_INC_EOF_FU: begin inc_c = 1'b1; fu_c = 1'b1; done_c = 1'b1; end
      F_INC_EOF_Z:  begin inc_c = 1'b1; done_c = iFlagZ; adv_c = !iFlagZ; end
      F_INC_EOF_NZ: begin inc_c = 1'b1; done_c = !iFlagZ; adv_c = iFlagZ; end
      F_JCB:        begin inc_c = 1'b1; jump_c = 1'b1; end
      default:      adv_c = 1'b1;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state     <= S_FETCH;
      upc       <= '0;
      opcode    <= '0;
      seq_error <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!iStall) begin
            opcode <= iMemData;
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          upc   <= iFlowIdx;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (exec) begin
            if (done_c) begin
              state <= S_FETCH;
            end else if (jump_c) begin
              upc <= iCbFlowIdx;
            end else if (adv_c) begin
              // Running past the last ROM word is a broken flow, not a wrap.
              if (upc == '1) begin
                seq_error <= 1'b1;
                state     <= S_HALT;
              end else begin
                upc <= upc + UADDR_W'(1);
              end
            end
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  assign oUopAddr   = upc;
  assign oUopExec   = exec;
  assign oIncPc     = exec & inc_c;
  assign oFlagUpd   = exec & fu_c;
  assign oInstrDone = exec & done_c;
  assign oOpcode    = opcode;
  assign oFetch     = (state == S_FETCH);
  assign oSeqError  = seq_error;

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Directed bench for dzcpu_uop_sequencer with behavioural ROM/LUTs and an
// expected-uop queue checked on every executing cycle.
module tb_dzcpu_uop_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mem_data = '0;
  logic       stall = 1'b1;
  logic [7:0] flow_idx;
  logic [7:0] cb_flow_idx;
  logic [3:0] uop_flow;
  logic       flag_z = 1'b0;
  logic [7:0] uop_addr;
  logic       uop_exec;
  logic       inc_pc;
  logic       flag_upd;
  logic [7:0] opcode;
  logic       fetch;
  logic       instr_done;
  logic       seq_error;

  logic [3:0] rom   [256];
  logic [7:0] lut   [256];
  logic [7:0] cblut [256];

  typedef struct packed {
    logic [7:0] addr;
    logic       inc;
    logic       fu;
    logic       done;
  } exp_t;

  exp_t q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  assign uop_flow    = rom[uop_addr];
  assign flow_idx    = lut[opcode];
  assign cb_flow_idx = cblut[mem_data];

  always #5 clk = ~clk;

  dzcpu_uop_sequencer #(.UADDR_W(8), .FLOW_W(4)) dut (
    .iClock     (clk),
    .iReset     (rst_n),
    .iMemData   (mem_data),
    .iStall     (stall),
    .iFlowIdx   (flow_idx),
    .iCbFlowIdx (cb_flow_idx),
    .iUopFlow   (uop_flow),
    .iFlagZ     (flag_z),
    .oUopAddr   (uop_addr),
    .oUopExec   (uop_exec),
    .oIncPc     (inc_pc),
    .oFlagUpd   (flag_upd),
    .oOpcode    (opcode),
    .oFetch     (fetch),
    .oInstrDone (instr_done),
    .oSeqError  (seq_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic i, input logic f, input logic d);
    q.push_back({a, i, f, d});
  endtask

  // Inputs are set before calling; checks this cycle's outputs, then clocks it.
  task automatic cycle();
    exp_t e;
    #1;
    if (uop_exec) begin
      if (q.size() == 0) begin
        chk("exec_without_expectation", 32'(uop_exec), 32'd0);
      end else begin
        e = q.pop_front();
        chk("uop_addr",   32'(uop_addr),   32'(e.addr));
        chk("inc_pc",     32'(inc_pc),     32'(e.inc));
        chk("flag_upd",   32'(flag_upd),   32'(e.fu));
        chk("instr_done", 32'(instr_done), 32'(e.done));
      end
    end else begin
      chk("idle_pulses", 32'({inc_pc, flag_upd, instr_done}), 32'd0);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic run_flow(input logic [7:0] op, input logic [7:0] cb, input int unsigned max_cycles);
    int unsigned n;
    mem_data = op;
    stall    = 1'b0;
    cycle();
    mem_data = cb;
    n = 0;
    while (!fetch && n < max_cycles) begin
      cycle();
      n++;
    end
    stall = 1'b1;
    chk("flow_end_fetch", 32'(fetch), 32'd1);
    chk("queue_drained", q.size(), 32'd0);
    chk("opcode_latched", 32'(opcode), 32'(op));
    q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr"},  32'(uop_addr), 32'd0);
    chk({tag, "_outs"},  32'({uop_exec, inc_pc, flag_upd, instr_done, seq_error}), 32'd0);
    chk({tag, "_opc"},   32'(opcode), 32'd0);
    chk({tag, "_fetch"}, 32'(fetch), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i] = 4'd0; lut[i] = 8'd0; cblut[i] = 8'd0;
    end
    rom[0] = 4'd3;
    lut[8'h3E] = 8'd26; rom[26] = 4'd1; rom[27] = 4'd1; rom[28] = 4'd2;
    lut[8'h20] = 8'd17; rom[17] = 4'd1; rom[18] = 4'd0; rom[19] = 4'd6;
    rom[20] = 4'd12; rom[21] = 4'd6; rom[22] = 4'd7;
    lut[8'hCB] = 8'd13; rom[13] = 4'd1; rom[14] = 4'd8; rom[15] = 4'd9;
    cblut[8'h37] = 8'd16; rom[16] = 4'd4;
    lut[8'h41] = 8'd30; rom[30] = 4'd5;
    lut[8'h06] = 8'd44; rom[44] = 4'd0; rom[45] = 4'd0; rom[46] = 4'd2;
    lut[8'h10] = 8'd253;

    repeat (2) @(posedge clk);
    #2;
    check_reset_values("reset");
    rst_n = 1'b1;
    cycle();

    push(8'd26, 1, 0, 0); push(8'd27, 1, 0, 0); push(8'd28, 0, 0, 1);
    run_flow(8'h3E, 8'h00, 10);

    push(8'd26, 1, 0, 0);
    mem_data = 8'h3E; stall = 1'b0;
    cycle(); cycle(); cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_addr_hold", 32'(uop_addr), 32'd27);
      chk("stall_exec_low", 32'(uop_exec), 32'd0);
    end
    stall = 1'b0;
    push(8'd27, 1, 0, 0); push(8'd28, 0, 0, 1);
    cycle(); cycle();
    stall = 1'b1;
    chk("stall_resume_fetch", 32'(fetch), 32'd1);
    chk("stall_queue_drained", q.size(), 32'd0);
    q.delete();

    flag_z = 1'b1;
    push(8'd17, 1, 0, 0); push(8'd18, 0, 0, 0); push(8'd19, 1, 0, 1);
    run_flow(8'h20, 8'h00, 10);

    flag_z = 1'b0;
    push(8'd17, 1, 0, 0); push(8'd18, 0, 0, 0); push(8'd19, 1, 0, 0);
    push(8'd20, 0, 0, 0); push(8'd21, 1, 0, 0); push(8'd22, 1, 0, 1);
    run_flow(8'h20, 8'h00, 12);

    push(8'd13, 1, 0, 0); push(8'd14, 0, 0, 0); push(8'd15, 1, 0, 0); push(8'd16, 0, 1, 1);
    run_flow(8'hCB, 8'h37, 10);

    push(8'd13, 1, 0, 0); push(8'd14, 0, 0, 0); push(8'd15, 1, 0, 0); push(8'd0, 1, 0, 1);
    run_flow(8'hCB, 8'h38, 10);

    push(8'd0, 1, 0, 1);
    run_flow(8'h00, 8'h00, 6);

    push(8'd30, 1, 1, 1);
    run_flow(8'h41, 8'h00, 6);

    push(8'd44, 0, 0, 0);
    mem_data = 8'h06; stall = 1'b0;
    cycle(); cycle(); cycle();
    chk("midflow_addr", 32'(uop_addr), 32'd45);
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1; stall = 1'b1;
    cycle(); cycle();
    chk("post_reset_fetch", 32'(fetch), 32'd1);
    chk("post_reset_queue", q.size(), 32'd0);
    q.delete();

    push(8'd253, 0, 0, 0); push(8'd254, 0, 0, 0); push(8'd255, 0, 0, 0);
    mem_data = 8'h10; stall = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("halt_seq_error", 32'(seq_error), 32'd1);
    chk("halt_fetch_low", 32'(fetch), 32'd0);
    chk("halt_exec_low", 32'(uop_exec), 32'd0);
    cycle(); cycle();
    chk("halt_addr_hold", 32'(uop_addr), 32'd255);
    chk("halt_still_error", 32'(seq_error), 32'd1);
    chk("halt_queue", q.size(), 32'd0);
    q.delete();
    rst_n = 1'b0;
    #1;
    check_reset_values("halt_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1; stall = 1'b1;
    cycle();

    push(8'd0, 1, 0, 1);
    run_flow(8'h00, 8'h00, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dzcpu_uop_sequencer.md
Name: dzcpu_uop_sequencer

Overview:
Microcode sequencer for the dzcpu core: fetches each macro-opcode, converts it to a micro-flow entry address, and steps the micro-PC through the ucode ROM until end-of-flow. It decodes the flow-control field of each ROM word (the inc/eof/jcb/conditional family) and drives PC-increment, flag-update and stall behaviour. It sits between the memory bus, the opcode/CB lookup tables and the ucode ROM, and it gates the datapath execute enable.

Parameters:
UADDR_W, 8, micro-PC width; ROM depth is 2**UADDR_W
FLOW_W, 4, width of the flow-control field taken from the ROM word

Ports:
iClock  in  1  core clock; all state on rising edge
iReset  in  1  asynchronous, active-low reset
iMemData  in  8  memory read data (opcode byte or CB second byte)
iStall  in  1  memory not ready; freeze sequencer this cycle
iFlowIdx  in  UADDR_W  entry address from the main opcode LUT, driven from oOpcode
iCbFlowIdx  in  UADDR_W  entry address from the CB LUT, driven from iMemData
iUopFlow  in  FLOW_W  flow field of the ROM word at oUopAddr
iFlagZ  in  1  current Z flag
oUopAddr  out  UADDR_W  micro-PC to ucode ROM
oUopExec  out  1  datapath executes the ROM word at oUopAddr this cycle
oIncPc  out  1  PC += 1 this cycle
oFlagUpd  out  1  latch ALU flags this cycle
oOpcode  out  8  latched macro-opcode
oFetch  out  1  sequencer is in the opcode-fetch state
oInstrDone  out  1  one-cycle pulse on the final uop of a flow
oSeqError  out  1  sticky: flow ran off ROM end without eof

Behaviour:
- Flow encodings: OP=0, INC=1, EOF=2, INC_EOF=3, EOF_FU=4, INC_EOF_FU=5, INC_EOF_Z=6, INC_EOF_NZ=7, NOP=8, JCB=9. Codes 10-15 are treated as OP.
- States: FETCH, DECODE, EXEC, HALT. Reset enters FETCH.
- Reset values: oUopAddr=0, oUopExec=0, oIncPc=0, oFlagUpd=0, oOpcode=8'h00, oFetch=1, oInstrDone=0, oSeqError=0. Reset asserted mid-flow aborts immediately with no completion pulse.
- oIncPc, oFlagUpd and oInstrDone are combinational from the state and iUopFlow, and are qualified by oUopExec.
- FETCH: oFetch=1. If iStall=0, latch oOpcode<=iMemData and go to DECODE. Otherwise hold.
- DECODE: uPC<=iFlowIdx, then go to EXEC. oUopExec=0. Total fetch-to-first-uop latency is 2 cycles with no stall.
- EXEC: oUopExec=~iStall. Stall freezes uPC and state, and forces all pulses to 0.
- EXEC with no stall, by flow code:
  - OP/NOP: uPC+1.
  - INC: oIncPc=1, uPC+1.
  - EOF: oInstrDone=1, go to FETCH.
  - INC_EOF: oIncPc=1, oInstrDone=1, go to FETCH.
  - EOF_FU: oFlagUpd=1, oInstrDone=1, go to FETCH.
  - INC_EOF_FU: oIncPc=1, oFlagUpd=1, oInstrDone=1, go to FETCH.
  - INC_EOF_Z: oIncPc=1. If iFlagZ=1, end (oInstrDone=1, go to FETCH). Otherwise uPC+1.
  - INC_EOF_NZ: same as INC_EOF_Z with the Z test inverted.
  - JCB: oIncPc=1, uPC<=iCbFlowIdx, stay in EXEC.
- On an ending uop, uPC is not modified; it holds its value through FETCH.
- CB LUT miss (iCbFlowIdx=0) executes flow 0 like any other entry.
- Wrap guard: a non-ending, non-JCB uop at uPC=2**UADDR_W-1 sets oSeqError=1 and goes to HALT instead of wrapping to 0.
- HALT: all pulses 0, oUopExec=0, oFetch=0. Only reset exits HALT.
- An opcode whose LUT entry is 0 runs flow 0 (single INC_EOF uop).

Test Plan:
- LDrn_a (iMemData=8'h3E, iFlowIdx=26), ROM flows INC,INC,EOF -> oUopAddr 26,27,28 over 3 exec cycles; oIncPc high on the first two; oInstrDone on addr 28; oFetch next cycle.
- JRNZ entry 17, flow at 19 = INC_EOF_Z with iFlagZ=1 -> flow ends at addr 19 (oInstrDone, oIncPc). Repeat with iFlagZ=0 -> runs 20,21,22, ends at 22.
- CB prefix 8'hCB entry 13, JCB at 15, iCbFlowIdx=16, flow 16=EOF_FU -> addresses 13,14,15,16; oIncPc at 13 and 15; oFlagUpd and oInstrDone at 16.
- iStall high for 3 cycles while at addr 27 -> oUopAddr holds 27, oUopExec=0, no pulses; resumes at 27 when iStall drops.
- Flow of OP codes starting at entry 253 -> executes 253,254,255; oSeqError=1 after 255; HALT with no further exec. Reset then clears oSeqError and returns to FETCH.
- Reset asserted while at addr 45 -> outputs take reset values asynchronously; after release, oFetch=1 and no oInstrDone pulse occurs.
